// File: rtl/dps_bridge_pkg.sv
// Shared types and the DPS address map for the CPU-to-DPS IO bridge.
// Optional read watchdog is enabled by defining DPS_BRIDGE_TIMEOUT_EN.
package dps_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Registers the DPS actually decodes; anything else gets an error response.
    localparam logic [31:0] DPS_UTIM64_LIMIT = 32'h0000_0074;
    localparam logic [31:0] DPS_ADDR_7C      = 32'h0000_007C;
    localparam logic [31:0] DPS_SCI_0        = 32'h0000_0100;
    localparam logic [31:0] DPS_SCI_1        = 32'h0000_0104;
    localparam logic [31:0] DPS_SCI_2        = 32'h0000_0108;
    localparam logic [31:0] DPS_MIMSR        = 32'h0000_0120;
    localparam logic [31:0] DPS_LSFLAGS      = 32'h0000_01FC;

    localparam int ENTRY_W = 66;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mapped;
    } entry_t;

    function automatic logic addr_mapped(input logic [31:0] addr);
        return (addr <= DPS_UTIM64_LIMIT) || (addr == DPS_ADDR_7C) ||
               (addr == DPS_SCI_0) || (addr == DPS_SCI_1) || (addr == DPS_SCI_2) ||
               (addr == DPS_MIMSR) || (addr == DPS_LSFLAGS);
    endfunction

endpackage

// File: rtl/dps_io_bridge_if.sv
// Push/pop bus between the bridge control logic (master) and its request FIFO (slave).
// Handshake: push is taken when !full (or when a pop happens in the same cycle); pop is taken when !empty; head is valid whenever !empty.
interface dps_io_bridge_if #(
    parameter int W = 66
);
    logic         push;
    logic [W-1:0] wdata;
    logic         pop;
    logic [W-1:0] head;
    logic         full;
    logic         empty;

    modport master (output push, output wdata, output pop,
                    input  head, input  full,  input  empty);
    modport slave  (input  push, input  wdata, input  pop,
                    output head, output full,  output empty);
endinterface

// File: rtl/dps_io_bridge_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full/empty come from a count compare.
module dps_io_bridge_fifo #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2,
    parameter int WIDTH   = 66
) (
    input  logic             iCLOCK,
    input  logic             inRESET,
    dps_io_bridge_if.slave   fifo_if
);

    localparam logic [DEPTH_N:0] DEPTH_CNT = (DEPTH_N + 1)'(DEPTH);
    localparam logic [DEPTH_N:0] PTR_ONE   = (DEPTH_N + 1)'(1);

    logic [DEPTH_N:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_N:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_N:0] count;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign count         = wr_ptr_q - rd_ptr_q;
    assign fifo_if.full  = (count == DEPTH_CNT);
    assign fifo_if.empty = (count == '0);
    assign fifo_if.head  = mem_q[rd_ptr_q[DEPTH_N-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = fifo_if.pop && !fifo_if.empty;
    assign do_push = fifo_if.push && (!fifo_if.full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[DEPTH_N-1:0]] = fifo_if.wdata;
            wr_ptr_d                     = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/dps_io_bridge.sv
// CPU IO port to DPS bridge: queues requests, issues them one at a time, returns reads in order.
// Define DPS_BRIDGE_TIMEOUT_EN to add a read watchdog of TIMEOUT_CYCLES cycles.
module dps_io_bridge
    import dps_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_DEPTH_N   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iCPU_REQ,
    output logic        oCPU_BUSY,
    input  logic        iCPU_RW,
    input  logic [31:0] iCPU_ADDR,
    input  logic [31:0] iCPU_DATA,
    output logic        oCPU_VALID,
    output logic [31:0] oCPU_DATA,
    output logic        oCPU_ERR,
    output logic        oDPS_REQ,
    input  logic        iDPS_BUSY,
    output logic        oDPS_RW,
    output logic [31:0] oDPS_ADDR,
    output logic [31:0] oDPS_DATA,
    input  logic        iDPS_VALID,
    input  logic [31:0] iDPS_DATA
);

    dps_io_bridge_if #(.W(ENTRY_W)) fifo_if ();

    dps_io_bridge_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .DEPTH_N (FIFO_DEPTH_N),
        .WIDTH   (ENTRY_W)
    ) u_fifo (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .fifo_if (fifo_if.slave)
    );

    entry_t push_entry;
    entry_t head_entry;
    logic   fifo_pop;

    // Decode once at push so the issue path only looks at a single flag.
    assign push_entry    = '{rw: iCPU_RW, addr: iCPU_ADDR, data: iCPU_DATA,
                             mapped: addr_mapped(iCPU_ADDR)};
    assign fifo_if.push  = iCPU_REQ && !fifo_if.full;
    assign fifo_if.wdata = push_entry;
    assign fifo_if.pop   = fifo_pop;
    assign head_entry    = entry_t'(fifo_if.head);
    assign oCPU_BUSY     = fifo_if.full;

    state_t      state_q,     state_d;
    logic        dps_req_q,   dps_req_d;
    logic        dps_rw_q,    dps_rw_d;
    logic [31:0] dps_addr_q,  dps_addr_d;
    logic [31:0] dps_data_q,  dps_data_d;
    logic        cpu_valid_q, cpu_valid_d;
    logic [31:0] cpu_data_q,  cpu_data_d;
    logic        cpu_err_q,   cpu_err_d;

`ifdef DPS_BRIDGE_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_RD_WAIT) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        dps_req_d   = 1'b0;
        dps_rw_d    = 1'b0;
        dps_addr_d  = '0;
        dps_data_d  = '0;
        cpu_valid_d = 1'b0;
        cpu_data_d  = '0;
        cpu_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_if.empty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fifo_if.empty) begin
                    state_d = ST_IDLE;
                end else if (!head_entry.mapped) begin
                    fifo_pop = 1'b1;
                    if (head_entry.rw) begin
                        state_d = ST_IDLE;
                    end else begin
                        cpu_valid_d = 1'b1;
                        cpu_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end
                end else if (!iDPS_BUSY) begin
                    fifo_pop   = 1'b1;
                    dps_req_d  = 1'b1;
                    dps_rw_d   = head_entry.rw;
                    dps_addr_d = head_entry.addr;
                    dps_data_d = head_entry.data;
                    state_d    = head_entry.rw ? ST_IDLE : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // Completion is staged here so oCPU_VALID lands one cycle after iDPS_VALID.
                if (iDPS_VALID) begin
                    cpu_valid_d = 1'b1;
                    cpu_data_d  = iDPS_DATA;
                    state_d     = ST_RESP;
                end
`ifdef DPS_BRIDGE_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    cpu_valid_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                state_d = fifo_if.empty ? ST_IDLE : ST_ISSUE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            dps_req_q   <= 1'b0;
            dps_rw_q    <= 1'b0;
            dps_addr_q  <= '0;
            dps_data_q  <= '0;
            cpu_valid_q <= 1'b0;
            cpu_data_q  <= '0;
            cpu_err_q   <= 1'b0;
`ifdef DPS_BRIDGE_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dps_req_q   <= dps_req_d;
            dps_rw_q    <= dps_rw_d;
            dps_addr_q  <= dps_addr_d;
            dps_data_q  <= dps_data_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_data_q  <= cpu_data_d;
            cpu_err_q   <= cpu_err_d;
`ifdef DPS_BRIDGE_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign oDPS_REQ   = dps_req_q;
    assign oDPS_RW    = dps_rw_q;
    assign oDPS_ADDR  = dps_addr_q;
    assign oDPS_DATA  = dps_data_q;
    assign oCPU_VALID = cpu_valid_q;
    assign oCPU_DATA  = cpu_data_q;
    assign oCPU_ERR   = cpu_err_q;

endmodule

// File: tb/tb_dps_io_bridge.sv
// Scoreboard bench for dps_io_bridge: queued DPS requests and CPU completions are checked in order.
module tb_dps_io_bridge;

  localparam int TO = 16;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iCPU_REQ = 1'b0;
  logic        iCPU_RW = 1'b0;
  logic [31:0] iCPU_ADDR = '0;
  logic [31:0] iCPU_DATA = '0;
  logic        iDPS_BUSY = 1'b0;
  logic        iDPS_VALID = 1'b0;
  logic [31:0] iDPS_DATA = '0;
  logic        oCPU_BUSY, oCPU_VALID, oCPU_ERR;
  logic [31:0] oCPU_DATA;
  logic        oDPS_REQ, oDPS_RW;
  logic [31:0] oDPS_ADDR, oDPS_DATA;

  dps_io_bridge #(
    .FIFO_DEPTH     (4),
    .FIFO_DEPTH_N   (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .iCLOCK     (iCLOCK),
    .inRESET    (inRESET),
    .iCPU_REQ   (iCPU_REQ),
    .oCPU_BUSY  (oCPU_BUSY),
    .iCPU_RW    (iCPU_RW),
    .iCPU_ADDR  (iCPU_ADDR),
    .iCPU_DATA  (iCPU_DATA),
    .oCPU_VALID (oCPU_VALID),
    .oCPU_DATA  (oCPU_DATA),
    .oCPU_ERR   (oCPU_ERR),
    .oDPS_REQ   (oDPS_REQ),
    .iDPS_BUSY  (iDPS_BUSY),
    .oDPS_RW    (oDPS_RW),
    .oDPS_ADDR  (oDPS_ADDR),
    .oDPS_DATA  (oDPS_DATA),
    .iDPS_VALID (iDPS_VALID),
    .iDPS_DATA  (iDPS_DATA)
  );

  // clock / cycle counter
  always #5 iCLOCK = ~iCLOCK;
  int cyc = 0;
  always @(posedge iCLOCK) cyc <= cyc + 1;

  // scoreboard
  logic [64:0] exp_dps_q[$];
  logic [32:0] exp_cpu_q[$];
  int checks = 0;
  int errors = 0;
  int last_req_cyc = 0;
  int last_cpu_cyc = 0;
  int last_val_cyc = 0;
  bit dps_auto = 1'b1;
  bit spurious_en = 1'b0;
  int resp_delay = 3;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic mapped(input logic [31:0] a);
    case (a)
      32'h7C, 32'h100, 32'h104, 32'h108, 32'h120, 32'h1FC: return 1'b1;
      default: return a <= 32'h74;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h120) ? 32'hA5A5_0001 : (32'h5A00_0000 | a);
  endfunction

  // monitor
  always @(negedge iCLOCK) begin
    if (inRESET) begin
      if (exp_dps_q.size() == 0) begin
        check("dps_spurious", oDPS_REQ, 0);
      end else if (oDPS_REQ) begin
        check("dps_req", {oDPS_RW, oDPS_ADDR, oDPS_DATA}, exp_dps_q.pop_front());
        last_req_cyc = cyc;
      end
      if (exp_cpu_q.size() == 0) begin
        check("cpu_spurious", oCPU_VALID, 0);
      end else if (oCPU_VALID) begin
        check("cpu_resp", {oCPU_ERR, oCPU_DATA}, exp_cpu_q.pop_front());
        last_cpu_cyc = cyc;
      end
      if (!oCPU_VALID) check("cpu_idle_zero", {oCPU_ERR, oCPU_DATA}, 0);
    end
  end

  // DPS responder
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge iCLOCK);
      if (inRESET && oDPS_REQ) begin
        if (!oDPS_RW && dps_auto) begin
          a = oDPS_ADDR;
          repeat (resp_delay) @(negedge iCLOCK);
          iDPS_VALID = 1'b1;
          iDPS_DATA  = rd_model(a);
          last_val_cyc = cyc;
          @(negedge iCLOCK);
          iDPS_VALID = 1'b0;
          iDPS_DATA  = '0;
        end else if (oDPS_RW && spurious_en) begin
          iDPS_VALID = 1'b1;
          iDPS_DATA  = 32'hDEAD_BEEF;
          @(negedge iCLOCK);
          iDPS_VALID = 1'b0;
          iDPS_DATA  = '0;
        end
      end
    end
  end

  // driver tasks (called on a negedge)
  task automatic cpu_push(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input bit tmo);
    int n = 0;
    while (oCPU_BUSY && n < 200) begin
      @(negedge iCLOCK);
      n++;
    end
    check("push_ready", oCPU_BUSY, 0);
    iCPU_REQ = 1'b1; iCPU_RW = rw; iCPU_ADDR = a; iCPU_DATA = d;
    if (mapped(a)) exp_dps_q.push_back({rw, a, d});
    if (!rw) exp_cpu_q.push_back((mapped(a) && !tmo) ? {1'b0, rd_model(a)} : {1'b1, 32'h0});
    @(negedge iCLOCK);
    iCPU_REQ = 1'b0; iCPU_RW = 1'b0; iCPU_ADDR = '0; iCPU_DATA = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_cpu_q.size() + exp_dps_q.size()) != 0 && n < 400) begin
      @(negedge iCLOCK);
      n++;
    end
    check(tag, exp_cpu_q.size() + exp_dps_q.size(), 0);
    repeat (4) @(negedge iCLOCK);
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, {oCPU_BUSY, oCPU_VALID, oCPU_ERR, oCPU_DATA}, 0);
    check(tag, {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int push_cyc;
    int n;
    logic [31:0] addr_tab [8];
    addr_tab = '{32'h0, 32'h74, 32'h7C, 32'h104, 32'h120, 32'h1FC, 32'h78, 32'h200};

    // reset values
    repeat (3) @(negedge iCLOCK);
    check_outs_zero("rst_outs");
    inRESET = 1'b1;
    @(negedge iCLOCK);

    // single mapped read, 3-cycle DPS response
    push_cyc = cyc + 1;
    cpu_push(1'b0, 32'h120, 32'h0, 1'b0);
    drain("t1_drain");
    check("t1_req_lat", last_req_cyc, push_cyc + 2);
    check("t1_rd_lat", last_cpu_cyc, last_val_cyc + 1);

    // fill FIFO behind a busy DPS
    iDPS_BUSY = 1'b1;
    cpu_push(1'b1, 32'h100, 32'h1000_0001, 1'b0);
    cpu_push(1'b1, 32'h104, 32'h1000_0002, 1'b0);
    cpu_push(1'b1, 32'h108, 32'h1000_0003, 1'b0);
    check("t2_busy_3", oCPU_BUSY, 0);
    cpu_push(1'b1, 32'h7C, 32'h1000_0004, 1'b0);
    check("t2_busy_4", oCPU_BUSY, 1);
    iCPU_REQ = 1'b1; iCPU_RW = 1'b1; iCPU_ADDR = 32'h120; iCPU_DATA = 32'hBAD0_0005;
    @(negedge iCLOCK);
    iCPU_REQ = 1'b0; iCPU_RW = 1'b0; iCPU_ADDR = '0; iCPU_DATA = '0;
    repeat (5) @(negedge iCLOCK);
    iDPS_BUSY = 1'b0;
    drain("t2_drain");

    // unmapped and boundary addresses
    cpu_push(1'b0, 32'h200, 32'h0, 1'b0);
    cpu_push(1'b1, 32'h200, 32'h1234, 1'b0);
    cpu_push(1'b0, 32'h74, 32'h0, 1'b0);
    cpu_push(1'b0, 32'h78, 32'h0, 1'b0);
    cpu_push(1'b0, 32'h10C, 32'h0, 1'b0);
    drain("t3_drain");

    // mixed sequence with a spurious DPS valid during the write
    spurious_en = 1'b1;
    cpu_push(1'b1, 32'h0, 32'hCAFE_0000, 1'b0);
    cpu_push(1'b0, 32'h4, 32'h0, 1'b0);
    cpu_push(1'b0, 32'h1FC, 32'h0, 1'b0);
    drain("t4_drain");
    spurious_en = 1'b0;

    // random traffic
    for (int i = 0; i < 12; i++) begin
      resp_delay = $urandom_range(1, 4);
      cpu_push(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 7)], $urandom, 1'b0);
    end
    drain("rand_drain");
    resp_delay = 3;

`ifdef DPS_BRIDGE_TIMEOUT_EN
    // read watchdog, then a late valid that must be ignored
    dps_auto = 1'b0;
    cpu_push(1'b0, 32'h10, 32'h0, 1'b1);
    drain("to_drain");
    check("to_lat", last_cpu_cyc, last_req_cyc + TO);
    iDPS_VALID = 1'b1; iDPS_DATA = 32'h1111_2222;
    @(negedge iCLOCK);
    iDPS_VALID = 1'b0; iDPS_DATA = '0;
    repeat (6) @(negedge iCLOCK);
    dps_auto = 1'b1;
`endif

    // reset while waiting on a read with two more queued
    dps_auto = 1'b0;
    cpu_push(1'b0, 32'h10, 32'h0, 1'b0);
    cpu_push(1'b0, 32'h14, 32'h0, 1'b0);
    cpu_push(1'b0, 32'h18, 32'h0, 1'b0);
    n = 0;
    while (exp_dps_q.size() != 2 && n < 50) begin
      @(negedge iCLOCK);
      n++;
    end
    check("t5_pre", exp_dps_q.size(), 2);
    @(negedge iCLOCK);
    #2;
    inRESET = 1'b0;
    exp_dps_q.delete();
    exp_cpu_q.delete();
    #1;
    check_outs_zero("t5_rst_outs");
    repeat (2) @(negedge iCLOCK);
    inRESET = 1'b1;
    dps_auto = 1'b1;
    repeat (20) @(negedge iCLOCK);
    cpu_push(1'b0, 32'h108, 32'h0, 1'b0);
    drain("t5_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
